// File: rtl/tb_mem_model.sv
// Dual-port (instr + data) behavioural memory with configurable grant delay,
// response latency, outstanding-request limit and an address-window error injector.
module tb_mem_model #(
  parameter int unsigned MEM_WORDS = 16384,
  parameter int unsigned GNT_DLY   = 0,
  parameter int unsigned RSP_DLY   = 1,
  parameter int unsigned MAX_OUTST = 2,
  parameter logic [31:0] ERR_BASE  = 32'hFFFF_0000,
  parameter logic [31:0] ERR_MASK  = 32'hFFFF_0000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        instr_req,
  input  logic [31:0] instr_addr,
  output logic        instr_gnt,
  output logic [31:0] instr_rdata,
  output logic        instr_err,
  output logic        instr_valid,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  input  logic [3:0]  data_byteen,
  output logic        data_gnt,
  output logic [31:0] data_rdata,
  output logic        data_valid,
  output logic        data_err
);

  localparam int unsigned AW  = $clog2(MEM_WORDS);
  localparam int unsigned WCW = (GNT_DLY < 1) ? 1 : $clog2(GNT_DLY + 1);
  localparam int unsigned OCW = $clog2(MAX_OUTST + 1);
  localparam int NP  = 2;
  localparam int P_I = 0;
  localparam int P_D = 1;

  typedef struct packed {
    logic        vld;
    logic [31:0] rdata;
    logic        err;
  } rsp_t;

  logic [31:0]   mem [MEM_WORDS];

  logic [NP-1:0] req, wr, gnt, hit_err;
  logic [31:0]   addr [NP];
  logic [AW-1:0] idx  [NP];
  rsp_t          rsp_out [NP];

  assign req     = {data_req, instr_req};
  assign wr      = {data_wr, 1'b0};
  assign addr[P_I] = instr_addr;
  assign addr[P_D] = data_addr;

  for (genvar p = 0; p < NP; p++) begin : g_port
    logic [WCW-1:0] wcnt_q, wcnt_d;
    logic [OCW-1:0] ocnt_q, ocnt_d;
    rsp_t           pipe_q [RSP_DLY];
    rsp_t           rsp_new;
    logic           win_hit, range_hit, rsp_pop;

    assign win_hit    = (addr[p] & ERR_MASK) == ERR_BASE;
    assign range_hit  = {2'b00, addr[p][31:2]} >= 32'(MEM_WORDS);
    assign hit_err[p] = win_hit | range_hit;
    assign idx[p]     = addr[p][AW+1:2];
    assign rsp_pop    = pipe_q[RSP_DLY-1].vld;

    // Grant is combinational from req so a zero-delay memory answers in the request cycle.
    assign gnt[p] = req[p] & (wcnt_q >= WCW'(GNT_DLY)) & (ocnt_q < OCW'(MAX_OUTST)) & reset_n;

    // NOTE: every signal written here gets a default first, so no latch can be inferred.
    always_comb begin
      wcnt_d = wcnt_q;
      if (!req[p] || gnt[p]) begin
        wcnt_d = '0;
      end else if (wcnt_q < WCW'(GNT_DLY)) begin
        wcnt_d = wcnt_q + WCW'(1);
      end

      ocnt_d = ocnt_q;
      if (gnt[p] && !rsp_pop) begin
        ocnt_d = ocnt_q + OCW'(1);
      end else if (!gnt[p] && rsp_pop) begin
        ocnt_d = ocnt_q - OCW'(1);
      end

      rsp_new.vld   = gnt[p];
      rsp_new.err   = gnt[p] & hit_err[p];
      rsp_new.rdata = (gnt[p] && !hit_err[p] && !wr[p]) ? mem[idx[p]] : '0;
    end

    // NOTE: non-blocking updates make every stage shift off the pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        wcnt_q <= '0;
        ocnt_q <= '0;
        for (int s = 0; s < RSP_DLY; s++) pipe_q[s] <= '0;
      end else begin
        wcnt_q    <= wcnt_d;
        ocnt_q    <= ocnt_d;
        pipe_q[0] <= rsp_new;
        for (int s = 1; s < RSP_DLY; s++) pipe_q[s] <= pipe_q[s-1];
      end
    end

    assign rsp_out[p] = pipe_q[RSP_DLY-1];
  end

  // NOTE: the storage array has no reset; contents survive reset_n and are preloaded by the bench.
  // The read for a same-cycle instr fetch happens before this edge commits, so it sees the old word.
  always_ff @(posedge clk) begin
    if (gnt[P_D] && data_wr && !hit_err[P_D]) begin
      for (int b = 0; b < 4; b++) begin
        if (data_byteen[b]) mem[idx[P_D]][8*b +: 8] <= data_wdata[8*b +: 8];
      end
    end
  end

  assign instr_gnt   = gnt[P_I];
  assign instr_valid = rsp_out[P_I].vld;
  assign instr_rdata = rsp_out[P_I].rdata;
  assign instr_err   = rsp_out[P_I].err;

  assign data_gnt    = gnt[P_D];
  assign data_valid  = rsp_out[P_D].vld;
  assign data_rdata  = rsp_out[P_D].rdata;
  assign data_err    = rsp_out[P_D].err;

endmodule
